reaction_counter: RTL and testbench

REACTION_COUNTER -- requirements
Module: reaction_counter

---
 rtl/reaction_counter_pkg.sv | 9 +
 rtl/reaction_counter_bcd_digit.sv | 28 ++
 rtl/reaction_counter.sv | 44 ++++
 tb/tb_reaction_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/reaction_counter_pkg.sv
// Shared types and constants for the reaction-time counter.
package reaction_counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam int   DEFAULT_TICK_DIV = 100000;
    localparam bcd_t BCD_MAX          = 4'd9;

endpackage

// File: rtl/reaction_counter_bcd_digit.sv
// One decimal digit of the counter: increments on carry-in, emits carry-out at 9.
import reaction_counter_pkg::*;

module bcd_digit (
    input  logic       clk,
    input  logic       clear,
    input  logic       zero,
    input  logic       cin,
    output logic [3:0] q,
    output logic       cout
);

    logic at_top;

    // Any value at or above 9 counts as terminal, so a stray A..F value
    // self-heals to 0 with a carry on its next increment.
    assign at_top = (q >= BCD_MAX);
    assign cout   = cin && at_top;

    always_ff @(posedge clk) begin
        if (clear || zero) begin
            q <= 4'd0;
        end else if (cin) begin
            q <= at_top ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/reaction_counter.sv
// Millisecond reaction counter: prescaler producing ticks, four chained BCD digits.
import reaction_counter_pkg::*;

module reaction_counter #(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       count_start,
    input  logic       count_clear,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       tick,
    output logic       rollover
);

    localparam logic [19:0] P_LAST = 20'(TICK_DIV - 1);

    logic [19:0] p;
    logic        enabled;
    logic [4:0]  carry;

    // clear is tested first so tick stays 0 even before p has a known value.
    assign enabled  = !clear && !count_clear && count_start;
    assign tick     = enabled && (p == P_LAST);
    assign carry[0] = tick;
    assign rollover = carry[4];

    always_ff @(posedge clk) begin
        if (clear || count_clear) begin
            p <= 20'd0;
        end else if (enabled) begin
            p <= (p == P_LAST) ? 20'd0 : p + 20'd1;
        end
    end

    bcd_digit u_d0 (.clk(clk), .clear(clear), .zero(count_clear), .cin(carry[0]), .q(d0), .cout(carry[1]));
    bcd_digit u_d1 (.clk(clk), .clear(clear), .zero(count_clear), .cin(carry[1]), .q(d1), .cout(carry[2]));
    bcd_digit u_d2 (.clk(clk), .clear(clear), .zero(count_clear), .cin(carry[2]), .q(d2), .cout(carry[3]));
    bcd_digit u_d3 (.clk(clk), .clear(clear), .zero(count_clear), .cin(carry[3]), .q(d3), .cout(carry[4]));

endmodule

// File: tb/tb_reaction_counter.sv
// Directed bench for reaction_counter with TICK_DIV=4.
module tb_reaction_counter;

    logic       clk;
    logic       clear;
    logic       count_start;
    logic       count_clear;
    logic [3:0] d0, d1, d2, d3;
    logic       tick;
    logic       rollover;

    int total;
    int bad;
    int exp_p;
    int exp_cnt;
    int tick_seen;
    int roll_seen;
    logic last_tick;

    reaction_counter #(.TICK_DIV(4)) dut (
        .clk(clk), .clear(clear), .count_start(count_start), .count_clear(count_clear),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .tick(tick), .rollover(rollover)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check the combinational pulses, clock, check digits.
    task automatic drive(input logic s, input logic cc, input logic clr);
        logic et, er;
        count_start = s;
        count_clear = cc;
        clear       = clr;
        #1;
        et = !clr && !cc && s && (exp_p == 3);
        er = et && (exp_cnt == 9999);
        check("tick", {15'd0, tick}, {15'd0, et});
        check("rollover", {15'd0, rollover}, {15'd0, er});
        last_tick = tick;
        if (tick === 1'b1) tick_seen++;
        if (rollover === 1'b1) roll_seen++;
        @(posedge clk);
        if (clr || cc) begin
            exp_p   = 0;
            exp_cnt = 0;
        end else if (s) begin
            if (exp_p == 3) begin
                exp_p   = 0;
                exp_cnt = (exp_cnt + 1) % 10000;
            end else begin
                exp_p = exp_p + 1;
            end
        end
        #1;
        check("digits", {d3, d2, d1, d0}, to_bcd(exp_cnt));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0);
    endtask

    // Enabled cycles until a tick is observed, bounded.
    task automatic cycles_to_tick(output int n);
        n = 0;
        last_tick = 1'b0;
        while (!last_tick && n < 20) begin
            drive(1'b1, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int lat;
        total = 0; bad = 0; exp_p = 0; exp_cnt = 0;
        tick_seen = 0; roll_seen = 0; last_tick = 1'b0;
        clear = 1'b1; count_start = 1'b1; count_clear = 1'b0;

        // reset with count_start high
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        check("reset_digits", {d3, d2, d1, d0}, 16'h0000);

        // basic count: 40 cycles -> 10 ticks, 0010
        tick_seen = 0;
        run(40);
        check("basic_ticks", 16'(tick_seen), 16'd10);
        check("basic_cnt", {d3, d2, d1, d0}, 16'h0010);

        // hold: p=2, freeze 7 cycles, resume needs 2 more cycles to tick
        run(2);
        tick_seen = 0;
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b0, 1'b0);
        check("hold_ticks", 16'(tick_seen), 16'd0);
        check("hold_cnt", {d3, d2, d1, d0}, 16'h0010);
        cycles_to_tick(lat);
        check("hold_resume_lat", 16'(lat), 16'd2);
        check("hold_resume_cnt", {d3, d2, d1, d0}, 16'h0011);

        // latency from p=0 is exactly TICK_DIV cycles
        drive(1'b0, 1'b1, 1'b0);
        cycles_to_tick(lat);
        check("start_lat", 16'(lat), 16'd4);

        // carry: 999 ticks -> 0999, one more -> 1000
        drive(1'b0, 1'b1, 1'b0);
        run(999 * 4);
        check("cnt_0999", {d3, d2, d1, d0}, 16'h0999);
        run(4);
        check("cnt_1000", {d3, d2, d1, d0}, 16'h1000);

        // wrap: up to 9999, then one tick -> 0000 with one rollover pulse
        run(8999 * 4);
        check("cnt_9999", {d3, d2, d1, d0}, 16'h9999);
        roll_seen = 0;
        run(3);
        check("pre_wrap_roll", 16'(roll_seen), 16'd0);
        run(1);
        check("cnt_wrap", {d3, d2, d1, d0}, 16'h0000);
        run(8);
        check("roll_pulses", 16'(roll_seen), 16'd1);

        // collision: count_clear on the terminal prescaler cycle
        drive(1'b0, 1'b1, 1'b0);
        run(7);
        check("coll_pre", {d3, d2, d1, d0}, 16'h0001);
        tick_seen = 0;
        drive(1'b1, 1'b1, 1'b0);
        check("coll_ticks", 16'(tick_seen), 16'd0);
        check("coll_cnt", {d3, d2, d1, d0}, 16'h0000);
        cycles_to_tick(lat);
        check("coll_lat", 16'(lat), 16'd4);

        // reset mid-operation at 0537, p=2
        drive(1'b0, 1'b1, 1'b0);
        run(537 * 4 + 2);
        check("cnt_0537", {d3, d2, d1, d0}, 16'h0537);
        drive(1'b1, 1'b1, 1'b1);
        check("midreset_cnt", {d3, d2, d1, d0}, 16'h0000);
        cycles_to_tick(lat);
        check("midreset_lat", 16'(lat), 16'd4);
        check("midreset_after", {d3, d2, d1, d0}, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
